// File: rtl/score_history_if.sv
// score_history_if: groups the game-side score/browse controls and the display-side outputs.
// Latency: none; plain wires between the game logic and the history stage.
// Backpressure: none; all inputs are single-cycle pulses that the history stage always accepts.
interface score_history_if #(
  parameter int DEPTH = 8
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             clear;
  logic             score_valid;
  logic [15:0]      score;
  logic             browse;
  logic [31:0]      hex;
  logic [15:0]      best;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] sel_idx;

  // Game side: drives the round events, observes the display.
  modport master (
    output clear, score_valid, score, browse,
    input  hex, best, count, sel_idx
  );

  // History stage side.
  modport slave (
    input  clear, score_valid, score, browse,
    output hex, best, count, sel_idx
  );
endinterface

// File: rtl/score_history.sv
// score_history: circular round-score history with best-score tracking and 7-segment display of newest or browsed entry.
// Latency: count/best/state/sel_idx update on the sampling edge; hex is one register stage behind.
// Backpressure: none; every pulse is accepted, browse is dropped when it collides with clear or score_valid.
module score_history #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 3000
) (
  input  logic           mclk,
  input  logic           reset,
  score_history_if.slave bus
);
  localparam int          PTR_W     = $clog2(DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam int          IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [15:0] BEST_INIT = 16'h9999;
  localparam logic [31:0] HEX_DASH  = 32'hBFBFBFBF;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LAST   = 2'd1,
    ST_BROWSE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, sel_idx, sel_nxt, rd_ptr;
  logic [CNT_W-1:0]  count, sel_inc;
  logic [15:0]       best, entry;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic [31:0]       hex, hex_nxt;
  logic              write_ev, browse_ev, timeout_ev, sel_wrap;
  logic              show_dash, dp_on;

  // Event qualification encodes the priority clear > score_valid > browse > timeout.
  assign write_ev   = bus.score_valid & ~bus.clear;
  assign browse_ev  = bus.browse & ~bus.score_valid & ~bus.clear;
  assign timeout_ev = (state == ST_BROWSE) & ~bus.browse & ~bus.score_valid & ~bus.clear
                    & (idle_cnt == IDLE_W'(TIMEOUT - 1));
  assign sel_inc    = {1'b0, sel_idx} + CNT_W'(1);
  assign sel_wrap   = (sel_inc == count);

  // State register.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = ST_EMPTY;
    end else if (bus.score_valid) begin
      state_nxt = ST_LAST;
    end else if (browse_ev) begin
      case (state)
        ST_LAST:   if (count > CNT_W'(1)) state_nxt = ST_BROWSE;
        ST_BROWSE: if (sel_wrap) state_nxt = ST_LAST;
        default:   state_nxt = state;
      endcase
    end else if (timeout_ev) begin
      state_nxt = ST_LAST;
    end
  end

  // FSM outputs: browse offset and idle counter follow the next state; display controls follow the current one.
  always_comb begin
    sel_nxt   = sel_idx;
    idle_nxt  = idle_cnt;
    show_dash = (state == ST_EMPTY);
    dp_on     = (state == ST_BROWSE);
    if (state_nxt != ST_BROWSE) begin
      sel_nxt  = '0;
      idle_nxt = '0;
    end else if ((state != ST_BROWSE) || browse_ev) begin
      // Entering BROWSE from LAST yields 0+1 = 1; a browse within BROWSE steps back one entry.
      sel_nxt  = sel_inc[PTR_W-1:0];
      idle_nxt = '0;
    end else begin
      idle_nxt = idle_cnt + IDLE_W'(1);
    end
  end

  // Browse offset and idle counter registers.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      sel_idx  <= '0;
      idle_cnt <= '0;
    end else begin
      sel_idx  <= sel_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  // History bookkeeping: write pointer, saturating fill count and best score.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
      best   <= BEST_INIT;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      count  <= '0;
      best   <= BEST_INIT;
    end else if (bus.score_valid) begin
      // DEPTH is a power of two, so the pointer wraps on its own.
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
      if (bus.score < best) best <= bus.score;
    end
  end

  // Score storage; contents are don't-care while count is zero, so no reset.
  always_ff @(posedge mclk) begin
    if (write_ev) mem[wr_ptr] <= bus.score;
  end

  // Newest entry sits just behind the write pointer; sel_idx walks further back.
  assign rd_ptr = wr_ptr - PTR_W'(1) - sel_idx;
  assign entry  = mem[rd_ptr];

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Display decode: dashes when empty, otherwise four digits with the HEX0 dp marking BROWSE.
  always_comb begin
    hex_nxt = {seg7(entry[15:12]), seg7(entry[11:8]), seg7(entry[7:4]), seg7(entry[3:0])};
    if (dp_on) hex_nxt[7] = 1'b0;
    if (show_dash) hex_nxt = HEX_DASH;
  end

  // Display register stage.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) hex <= HEX_DASH;
    else       hex <= hex_nxt;
  end

  assign bus.hex     = hex;
  assign bus.best    = best;
  assign bus.count   = count;
  assign bus.sel_idx = sel_idx;
endmodule

// File: tb/tb_score_history.sv
// tb_score_history: directed test-plan steps plus randomized traffic against a queue-based history model.
// Latency: expects state updates on the sampling edge and hex one edge later.
// Backpressure: none; the bench drives one set of pulses per mclk cycle.
module tb_score_history;
  localparam int DEPTH      = 8;
  localparam int TB_TIMEOUT = 50;

  logic mclk;
  logic reset;
  int   checks;
  int   errors;

  score_history_if #(.DEPTH(DEPTH)) bif ();

  score_history #(.DEPTH(DEPTH), .TIMEOUT(TB_TIMEOUT)) dut (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bif)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Reference model: history as a queue (oldest first), mode 0=empty 1=last 2=browse.
  logic [15:0] q [$];
  logic [15:0] m_best;
  int          m_mode;
  int          m_sel;
  int          m_idle;
  logic [31:0] exp_hex;
  logic [7:0]  seg [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  function automatic logic [31:0] disp();
    logic [15:0] e;
    logic [31:0] h;
    if (m_mode == 0) return 32'hBFBFBFBF;
    e = q[q.size() - 1 - m_sel];
    for (int d = 0; d < 4; d++) h[d*8 +: 8] = seg[e[d*4 +: 4]];
    if (m_mode == 2) h[7] = 1'b0;
    return h;
  endfunction

  task automatic model_reset();
    q.delete();
    m_best  = 16'h9999;
    m_mode  = 0;
    m_sel   = 0;
    m_idle  = 0;
    exp_hex = 32'hBFBFBFBF;
  endtask

  task automatic model_edge(input logic c, input logic v, input logic [15:0] s, input logic b);
    exp_hex = disp();
    if (c) begin
      q.delete();
      m_best = 16'h9999;
      m_mode = 0;
      m_sel  = 0;
      m_idle = 0;
    end else if (v) begin
      q.push_back(s);
      if (q.size() > DEPTH) void'(q.pop_front());
      if (s < m_best) m_best = s;
      m_mode = 1;
      m_sel  = 0;
      m_idle = 0;
    end else if (b) begin
      if (m_mode == 1 && q.size() > 1) begin
        m_mode = 2;
        m_sel  = 1;
        m_idle = 0;
      end else if (m_mode == 2) begin
        m_sel  = m_sel + 1;
        m_idle = 0;
        if (m_sel == q.size()) begin
          m_mode = 1;
          m_sel  = 0;
        end
      end
    end else if (m_mode == 2) begin
      m_idle = m_idle + 1;
      if (m_idle == TB_TIMEOUT) begin
        m_mode = 1;
        m_sel  = 0;
        m_idle = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".hex"},     bif.hex,            exp_hex);
    chk({tag, ".best"},    32'(bif.best),      32'(m_best));
    chk({tag, ".count"},   32'(bif.count),     32'(q.size()));
    chk({tag, ".sel_idx"}, 32'(bif.sel_idx),   32'(m_sel));
  endtask

  // One mclk cycle with the given pulses; outputs are compared 1 time unit after the edge.
  task automatic cycle(input logic c, input logic v, input logic [15:0] s, input logic b);
    bif.clear       = c;
    bif.score_valid = v;
    bif.score       = s;
    bif.browse      = b;
    @(posedge mclk);
    model_edge(c, v, s, b);
    #1;
    bif.clear       = 1'b0;
    bif.score_valid = 1'b0;
    bif.score       = 16'h0;
    bif.browse      = 1'b0;
    check_model("cyc");
  endtask

  function automatic logic [15:0] rand_score();
    logic [15:0] s;
    for (int d = 0; d < 4; d++) s[d*4 +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 9) == 0) s[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
    return s;
  endfunction

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    bif.clear       = 1'b0;
    bif.score_valid = 1'b0;
    bif.score       = 16'h0;
    bif.browse      = 1'b0;
    model_reset();
    #12;
    reset = 1'b0;
    #1;

    // Reset state, and browse while empty keeps the dashes.
    chk("rst.hex",   bif.hex,          32'hBFBFBFBF);
    chk("rst.best",  32'(bif.best),    32'h9999);
    chk("rst.count", 32'(bif.count),   32'd0);
    chk("rst.sel",   32'(bif.sel_idx), 32'd0);
    cycle(0, 0, 16'h0, 1);
    cycle(0, 0, 16'h0, 1);
    chk("empty_browse.hex", bif.hex, 32'hBFBFBFBF);

    // Three writes, newest shown one edge later.
    cycle(0, 1, 16'h0250, 0);
    cycle(0, 1, 16'h0183, 0);
    cycle(0, 1, 16'h0312, 0);
    chk("wr3.count", 32'(bif.count), 32'd3);
    chk("wr3.best",  32'(bif.best),  32'h0183);
    cycle(0, 0, 16'h0, 0);
    chk("wr3.hex", bif.hex, 32'hC0B0F9A4);

    // Browse through the three entries and wrap back to the newest.
    cycle(0, 0, 16'h0, 1);
    chk("br1.sel", 32'(bif.sel_idx), 32'd1);
    cycle(0, 0, 16'h0, 0);
    chk("br1.hex", bif.hex, 32'hC0F98030);
    cycle(0, 0, 16'h0, 1);
    chk("br2.sel", 32'(bif.sel_idx), 32'd2);
    cycle(0, 0, 16'h0, 0);
    chk("br2.hex", bif.hex, 32'hC0A49240);
    cycle(0, 0, 16'h0, 1);
    chk("br3.sel", 32'(bif.sel_idx), 32'd0);
    cycle(0, 0, 16'h0, 0);
    chk("br3.hex", bif.hex, 32'hC0B0F9A4);

    // Overfill: 0001..0009, oldest overwritten.
    for (int i = 1; i <= 9; i++) cycle(0, 1, 16'(i), 0);
    cycle(0, 0, 16'h0, 0);
    chk("full.count", 32'(bif.count), 32'd8);
    chk("full.hex",   bif.hex,        32'hC0C0C090);
    for (int i = 0; i < 7; i++) cycle(0, 0, 16'h0, 1);
    cycle(0, 0, 16'h0, 0);
    chk("full.oldest_hex", bif.hex,         32'hC0C0C024);
    chk("full.best",       32'(bif.best),   32'h0001);
    cycle(0, 0, 16'h0, 1);
    chk("full.wrap_sel", 32'(bif.sel_idx), 32'd0);

    // Timeout: the last browse edge plus TIMEOUT edges returns to LAST.
    cycle(0, 0, 16'h0, 1);
    for (int i = 0; i < TB_TIMEOUT - 1; i++) cycle(0, 0, 16'h0, 0);
    chk("tmo.before", 32'(bif.sel_idx), 32'd1);
    cycle(0, 0, 16'h0, 0);
    chk("tmo.at", 32'(bif.sel_idx), 32'd0);
    cycle(0, 0, 16'h0, 0);
    chk("tmo.hex", bif.hex, 32'hC0C0C090);

    // Score and browse together while browsing: the score wins.
    cycle(0, 0, 16'h0, 1);
    cycle(0, 1, 16'h0420, 1);
    chk("sim.sel", 32'(bif.sel_idx), 32'd0);
    cycle(0, 0, 16'h0, 0);
    chk("sim.hex", bif.hex, 32'hC099A4C0);

    // Clear while browsing.
    cycle(0, 0, 16'h0, 1);
    cycle(1, 0, 16'h0, 0);
    chk("clr.count", 32'(bif.count), 32'd0);
    chk("clr.best",  32'(bif.best),  32'h9999);
    cycle(0, 0, 16'h0, 0);
    chk("clr.hex", bif.hex, 32'hBFBFBFBF);

    // Asynchronous reset between edges while browsing.
    cycle(0, 1, 16'h0777, 0);
    cycle(0, 1, 16'h0555, 0);
    cycle(0, 0, 16'h0, 1);
    cycle(0, 0, 16'h0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.hex",   bif.hex,          32'hBFBFBFBF);
    chk("arst.best",  32'(bif.best),    32'h9999);
    chk("arst.count", 32'(bif.count),   32'd0);
    chk("arst.sel",   32'(bif.sel_idx), 32'd0);
    model_reset();
    #1;
    reset = 1'b0;

    // Busy random traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cycle(r < 2, (r >= 2) && (r < 20), rand_score(), $urandom_range(0, 2) == 0);
    end
    // Sparse random traffic so idle timeouts occur.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      cycle(r < 3, (r >= 3) && (r < 23), rand_score(), $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
